block_ram_pingpong_ctrl: RTL and testbench

Ping-pong controller that splits one `block_ram_dual_port` instance (depth 2*BANK_DEPTH) into two banks and sequences it between one streaming producer and one random-access consumer. Port A is the write-only producer port; port B is the read-only consumer port. Feature-map writers fill one bank while the next layer reads the other. Bank ownership changes only by explicit completion handshakes.

---
 rtl/block_ram_pingpong_ctrl_if.sv | 40 ++++
 rtl/block_ram_pingpong_ctrl.sv | 131 +++++++++++++
 tb/tb_block_ram_pingpong_ctrl.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/block_ram_pingpong_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : block_ram_pingpong_ctrl_if
// Purpose  : Producer/consumer bundle for the ping-pong bank controller.
//            master = producer/consumer side, slave = controller side.
// Signals  : wr_valid/wr_ready/wr_data/wr_last   streaming producer
//            rd_bank_ready/rd_word_count          bank ownership status
//            rd_en/rd_addr/rd_data/rd_data_valid  random-access reads
//            rd_done                              consumer bank release
// Revision : 1.0 - initial release
// ============================================================================
interface block_ram_pingpong_ctrl_if #(
  parameter int DATA_WIDTH = 32,
  parameter int BANK_DEPTH = 1024
);
  localparam int AW = $clog2(BANK_DEPTH);

  logic                  wr_valid;
  logic                  wr_ready;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_last;
  logic                  rd_bank_ready;
  logic [AW:0]           rd_word_count;
  logic                  rd_en;
  logic [AW-1:0]         rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_data_valid;
  logic                  rd_done;

  modport master (
    output wr_valid, wr_data, wr_last, rd_en, rd_addr, rd_done,
    input  wr_ready, rd_bank_ready, rd_word_count, rd_data, rd_data_valid
  );

  modport slave (
    input  wr_valid, wr_data, wr_last, rd_en, rd_addr, rd_done,
    output wr_ready, rd_bank_ready, rd_word_count, rd_data, rd_data_valid
  );
endinterface
`default_nettype wire

// File: rtl/block_ram_pingpong_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : block_ram_pingpong_ctrl
// Purpose  : Splits one dual-port block RAM (2*BANK_DEPTH words) into two
//            banks. A streaming producer fills one bank through RAM port A
//            while a random-access consumer reads the other through port B.
//            Ownership moves only on bank completion (producer) and rd_done
//            (consumer).
// Ports    : clk, rst_n            clock, async active-low reset
//            bus (slave)           producer/consumer handshakes
//            ram_*_a               RAM port A (write only)
//            ram_*_b               RAM port B (read only)
// Revision : 1.0 - initial release
// ============================================================================
module block_ram_pingpong_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int BANK_DEPTH = 1024
) (
  input  wire                               clk,
  input  wire                               rst_n,
  block_ram_pingpong_ctrl_if.slave          bus,
  output logic [$clog2(BANK_DEPTH):0]       ram_addr_a,
  output logic [$clog2(BANK_DEPTH):0]       ram_addr_b,
  output logic [DATA_WIDTH-1:0]             ram_wr_data_a,
  output logic                              ram_wr_en_a,
  output logic                              ram_rd_en_a,
  output logic                              ram_wr_en_b,
  output logic [DATA_WIDTH-1:0]             ram_wr_data_b,
  output logic                              ram_rd_en_b,
  input  wire  [DATA_WIDTH-1:0]             ram_rd_data_b
);

  localparam int            AW       = $clog2(BANK_DEPTH);
  localparam logic [AW-1:0] LAST_PTR = AW'(BANK_DEPTH - 1);

  // State
  logic [1:0]    full_q, full_d;
  logic          wr_bank_q, wr_bank_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic          rd_bank_q, rd_bank_d;
  logic [AW:0]   cnt0_q, cnt0_d;
  logic [AW:0]   cnt1_q, cnt1_d;
  logic          rd_data_valid_q, rd_data_valid_d;

  // Handshake decode
  logic        wr_ready;
  logic        wr_accept;
  logic        wr_complete;
  logic        rd_bank_ready;
  logic        rd_accept;
  logic        rd_release;
  logic [AW:0] fill_count;

  // Gating with rst_n keeps wr_ready low for the whole reset window.
  assign wr_ready      = rst_n & ~full_q[wr_bank_q];
  assign wr_accept     = bus.wr_valid & wr_ready;
  // A bank closes on wr_last or when its final word is written.
  assign wr_complete   = wr_accept & (bus.wr_last | (wr_ptr_q == LAST_PTR));
  assign fill_count    = {1'b0, wr_ptr_q} + {{AW{1'b0}}, 1'b1};

  assign rd_bank_ready = full_q[rd_bank_q];
  assign rd_accept     = bus.rd_en & rd_bank_ready;
  assign rd_release    = bus.rd_done & rd_bank_ready;

  // Producer / RAM port A
  assign bus.wr_ready  = wr_ready;
  assign ram_addr_a    = {wr_bank_q, wr_ptr_q};
  assign ram_wr_data_a = bus.wr_data;
  assign ram_wr_en_a   = wr_accept;
  assign ram_rd_en_a   = 1'b0;

  // Consumer / RAM port B
  assign ram_addr_b    = {rd_bank_q, bus.rd_addr};
  assign ram_rd_en_b   = rd_accept;
  assign ram_wr_en_b   = 1'b0;
  assign ram_wr_data_b = '0;

  assign bus.rd_bank_ready = rd_bank_ready;
  assign bus.rd_word_count = rd_bank_ready ? (rd_bank_q ? cnt1_q : cnt0_q) : '0;
  assign bus.rd_data       = ram_rd_data_b;
  assign bus.rd_data_valid = rd_data_valid_q;

  always_comb begin
    full_d          = full_q;
    wr_bank_d       = wr_bank_q;
    wr_ptr_d        = wr_ptr_q;
    rd_bank_d       = rd_bank_q;
    cnt0_d          = cnt0_q;
    cnt1_d          = cnt1_q;
    rd_data_valid_d = rd_accept;

    if (wr_complete) begin
      full_d[wr_bank_q] = 1'b1;
      if (wr_bank_q) cnt1_d = fill_count;
      else           cnt0_d = fill_count;
      wr_bank_d = ~wr_bank_q;
      wr_ptr_d  = '0;
    end else if (wr_accept) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end

    // The completing bank is never the released one (it was not full), so
    // both updates can land on the same edge without conflict.
    if (rd_release) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = ~rd_bank_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q          <= '0;
      wr_bank_q       <= 1'b0;
      wr_ptr_q        <= '0;
      rd_bank_q       <= 1'b0;
      cnt0_q          <= '0;
      cnt1_q          <= '0;
      rd_data_valid_q <= 1'b0;
    end else begin
      full_q          <= full_d;
      wr_bank_q       <= wr_bank_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_bank_q       <= rd_bank_d;
      cnt0_q          <= cnt0_d;
      cnt1_q          <= cnt1_d;
      rd_data_valid_q <= rd_data_valid_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_block_ram_pingpong_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_block_ram_pingpong_ctrl
// Purpose  : Directed bench for block_ram_pingpong_ctrl with a behavioural
//            dual-port RAM (BANK_DEPTH=8, DATA_WIDTH=32).
// Revision : 1.0 - initial release
// ============================================================================
module tb_block_ram_pingpong_ctrl;

  localparam int DW = 32;
  localparam int BD = 8;
  localparam int AW = $clog2(BD);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  block_ram_pingpong_ctrl_if #(.DATA_WIDTH(DW), .BANK_DEPTH(BD)) bus_if ();

  logic [AW:0]   ram_addr_a, ram_addr_b;
  logic [DW-1:0] ram_wr_data_a, ram_wr_data_b, ram_rd_data_b;
  logic          ram_wr_en_a, ram_rd_en_a, ram_wr_en_b, ram_rd_en_b;

  block_ram_pingpong_ctrl #(.DATA_WIDTH(DW), .BANK_DEPTH(BD)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus           (bus_if),
    .ram_addr_a    (ram_addr_a),
    .ram_addr_b    (ram_addr_b),
    .ram_wr_data_a (ram_wr_data_a),
    .ram_wr_en_a   (ram_wr_en_a),
    .ram_rd_en_a   (ram_rd_en_a),
    .ram_wr_en_b   (ram_wr_en_b),
    .ram_wr_data_b (ram_wr_data_b),
    .ram_rd_en_b   (ram_rd_en_b),
    .ram_rd_data_b (ram_rd_data_b)
  );

  // Behavioural synchronous dual-port RAM, contents survive reset.
  logic [DW-1:0] mem [2*BD];
  logic [DW-1:0] ram_q;
  always @(posedge clk) begin
    if (ram_wr_en_a) mem[ram_addr_a] <= ram_wr_data_a;
    if (ram_rd_en_b) ram_q <= mem[ram_addr_b];
  end
  assign ram_rd_data_b = ram_q;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus_if.wr_valid = 1'b0;
    bus_if.wr_data  = '0;
    bus_if.wr_last  = 1'b0;
    bus_if.rd_en    = 1'b0;
    bus_if.rd_addr  = '0;
    bus_if.rd_done  = 1'b0;
  endtask

  initial begin
    idle_inputs();

    // ---- Reset ----
    repeat (2) @(negedge clk);
    #1;
    chk("rst_wr_ready_low", 64'(bus_if.wr_ready), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_wr_ready", 64'(bus_if.wr_ready), 64'd1);
    chk("rst_bank_ready", 64'(bus_if.rd_bank_ready), 64'd0);
    chk("rst_word_count", 64'(bus_if.rd_word_count), 64'd0);
    chk("rst_rd_valid", 64'(bus_if.rd_data_valid), 64'd0);
    chk("rst_wr_en_a", 64'(ram_wr_en_a), 64'd0);
    chk("rst_addr_a", 64'(ram_addr_a), 64'd0);
    chk("const_rd_en_a", 64'(ram_rd_en_a), 64'd0);
    chk("const_wr_en_b", 64'(ram_wr_en_b), 64'd0);
    chk("const_wr_data_b", 64'(ram_wr_data_b), 64'd0);

    // ---- Partial fill of bank 0: 0x10..0x14, wr_last on 5th ----
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus_if.wr_valid = 1'b1;
      bus_if.wr_data  = 32'h10 + 32'(i);
      bus_if.wr_last  = (i == 4);
      #1;
      chk("fill_wr_en_a", 64'(ram_wr_en_a), 64'd1);
      chk("fill_addr_a", 64'(ram_addr_a), 64'(i));
      chk("fill_wr_data_a", 64'(ram_wr_data_a), 64'h10 + 64'(i));
    end
    @(negedge clk);
    idle_inputs();
    #1;
    chk("fill_bank_ready", 64'(bus_if.rd_bank_ready), 64'd1);
    chk("fill_word_count", 64'(bus_if.rd_word_count), 64'd5);
    chk("fill_next_addr_a", 64'(ram_addr_a), 64'd8);

    // ---- Reads addr 0..4 back to back ----
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus_if.rd_en   = 1'b1;
      bus_if.rd_addr = 3'(i);
      #1;
      chk("rd_en_b", 64'(ram_rd_en_b), 64'd1);
      chk("rd_addr_b", 64'(ram_addr_b), 64'(i));
      if (i > 0) begin
        chk("rd_valid", 64'(bus_if.rd_data_valid), 64'd1);
        chk("rd_data", 64'(bus_if.rd_data), 64'h10 + 64'(i - 1));
      end
    end
    @(negedge clk);
    idle_inputs();
    #1;
    chk("rd_valid_last", 64'(bus_if.rd_data_valid), 64'd1);
    chk("rd_data_last", 64'(bus_if.rd_data), 64'h14);
    @(negedge clk);
    #1;
    chk("rd_valid_drop", 64'(bus_if.rd_data_valid), 64'd0);
    chk("rd_data_hold", 64'(bus_if.rd_data), 64'h14);

    // ---- Release bank 0 ----
    @(negedge clk);
    bus_if.rd_done = 1'b1;
    @(negedge clk);
    idle_inputs();
    #1;
    chk("rel_bank_ready", 64'(bus_if.rd_bank_ready), 64'd0);
    chk("rel_word_count", 64'(bus_if.rd_word_count), 64'd0);

    // ---- Ignored requests while no bank is ready ----
    @(negedge clk);
    bus_if.rd_en   = 1'b1;
    bus_if.rd_done = 1'b1;
    bus_if.rd_addr = 3'd3;
    #1;
    chk("ign_rd_en_b", 64'(ram_rd_en_b), 64'd0);
    @(negedge clk);
    idle_inputs();
    #1;
    chk("ign_rd_valid", 64'(bus_if.rd_data_valid), 64'd0);
    chk("ign_bank_ready", 64'(bus_if.rd_bank_ready), 64'd0);
    chk("ign_wr_ready", 64'(bus_if.wr_ready), 64'd1);
    chk("ign_addr_a", 64'(ram_addr_a), 64'd8);

    // ---- Auto-complete: 16 beats without wr_last (bank1 then bank0) ----
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      bus_if.wr_valid = 1'b1;
      bus_if.wr_data  = 32'h100 + 32'(i);
      #1;
      if (i == 0 || i == 7 || i == 8 || i == 15) begin
        chk("auto_wr_ready", 64'(bus_if.wr_ready), 64'd1);
        chk("auto_addr_a", 64'(ram_addr_a), (i < 8) ? 64'(8 + i) : 64'(i - 8));
      end
    end
    @(negedge clk);
    bus_if.wr_data = 32'h200;
    #1;
    chk("bp_wr_ready", 64'(bus_if.wr_ready), 64'd0);
    chk("bp_wr_en_a", 64'(ram_wr_en_a), 64'd0);
    chk("bp_bank_ready", 64'(bus_if.rd_bank_ready), 64'd1);
    chk("bp_word_count", 64'(bus_if.rd_word_count), 64'd8);
    @(negedge clk);
    #1;
    chk("bp_held_off", 64'(ram_wr_en_a), 64'd0);

    // ---- Same-cycle read (bank1 addr 2) and release ----
    bus_if.rd_en   = 1'b1;
    bus_if.rd_addr = 3'd2;
    bus_if.rd_done = 1'b1;
    #1;
    chk("rdd_rd_en_b", 64'(ram_rd_en_b), 64'd1);
    chk("rdd_addr_b", 64'(ram_addr_b), 64'd10);
    @(negedge clk);
    bus_if.rd_en   = 1'b0;
    bus_if.rd_done = 1'b0;
    #1;
    chk("rdd_valid", 64'(bus_if.rd_data_valid), 64'd1);
    chk("rdd_data", 64'(bus_if.rd_data), 64'h102);
    chk("rdd_bank_ready", 64'(bus_if.rd_bank_ready), 64'd1);
    chk("rdd_word_count", 64'(bus_if.rd_word_count), 64'd8);
    chk("rdd_wr_ready", 64'(bus_if.wr_ready), 64'd1);
    chk("rdd_wr_en_a", 64'(ram_wr_en_a), 64'd1);
    chk("rdd_addr_a", 64'(ram_addr_a), 64'd8);

    // ---- Two more beats into bank1, read bank0 (overwritten) ----
    @(negedge clk);
    bus_if.wr_data = 32'h201;
    bus_if.rd_en   = 1'b1;
    bus_if.rd_addr = 3'd7;
    #1;
    chk("b0_addr_b", 64'(ram_addr_b), 64'd7);
    chk("wr2_addr_a", 64'(ram_addr_a), 64'd9);
    @(negedge clk);
    bus_if.wr_data = 32'h202;
    bus_if.rd_addr = 3'd0;
    #1;
    chk("b0_data7", 64'(bus_if.rd_data), 64'h10f);
    @(negedge clk);
    bus_if.wr_valid = 1'b0;
    bus_if.rd_addr  = 3'd1;
    #1;
    chk("b0_data0", 64'(bus_if.rd_data), 64'h108);
    chk("wr3_addr_a", 64'(ram_addr_a), 64'd11);

    // ---- Reset mid-fill with a read pending ----
    @(negedge clk);
    #1;
    chk("pre_rst_valid", 64'(bus_if.rd_data_valid), 64'd1);
    idle_inputs();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(bus_if.rd_data_valid), 64'd0);
    chk("mid_rst_wr_ready", 64'(bus_if.wr_ready), 64'd0);
    chk("mid_rst_bank_ready", 64'(bus_if.rd_bank_ready), 64'd0);
    chk("mid_rst_addr_a", 64'(ram_addr_a), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus_if.wr_valid = 1'b1;
    bus_if.wr_data  = 32'h300;
    bus_if.wr_last  = 1'b1;
    #1;
    chk("post_rst_wr_en_a", 64'(ram_wr_en_a), 64'd1);
    chk("post_rst_addr_a", 64'(ram_addr_a), 64'd0);
    chk("post_rst_word_count", 64'(bus_if.rd_word_count), 64'd0);
    @(negedge clk);
    idle_inputs();
    bus_if.rd_en = 1'b1;
    #1;
    chk("post_rst_bank_ready", 64'(bus_if.rd_bank_ready), 64'd1);
    chk("post_rst_count1", 64'(bus_if.rd_word_count), 64'd1);
    chk("post_rst_addr_b", 64'(ram_addr_b), 64'd0);
    @(negedge clk);
    idle_inputs();
    #1;
    chk("post_rst_rd_valid", 64'(bus_if.rd_data_valid), 64'd1);
    chk("post_rst_rd_data", 64'(bus_if.rd_data), 64'h300);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
